// File: rtl/sin_osc_ctrl.sv
// Sine-oscillator sequencer: phase accumulator, quadrant fold, int-to-float, radian scaling
// through an embedded float multiplier, and start/done handshake with an external sin core.
module sin_osc_ctrl #(
  parameter logic [3:0]  PREC  = 4'd5,
  parameter logic [31:0] SCALE = 32'h30C90FDB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [31:0] phase_inc,
  input  logic        phase_load,
  input  logic [31:0] phase_init,
  output logic [31:0] sample,
  output logic        sample_valid,
  output logic        busy,
  output logic        overrun,
  output logic [31:0] trig_theta,
  output logic [3:0]  trig_prec,
  output logic        trig_start,
  input  logic [31:0] trig_result,
  input  logic        trig_done
);

  localparam int unsigned MulLat = 2;

  typedef enum logic [3:0] {
    StIdle,
    StFold,
    StConv,
    StScaleGo,
    StScaleWait,
    StTrigGo,
    StTrigGuard,
    StTrigWait,
    StOutput
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] phase_q, phase_d;
  logic [31:0] p_q, p_d;
  logic [31:0] fold_q, fold_d;
  logic [31:0] conv_q, conv_d;
  logic [31:0] theta_q, theta_d;
  logic [31:0] sample_q, sample_d;
  logic        sample_valid_q, sample_valid_d;
  logic        overrun_q, overrun_d;
  logic        first_q, first_d;
  logic [1:0]  mul_cnt_q, mul_cnt_d;
  logic [31:0] mul_res_q, mul_res_d;

  logic [31:0] base;

  // Quadrant fold into [-2^30, 2^30]
  logic signed [31:0] fold_s;
  logic signed [32:0] fold_x;
  logic signed [32:0] fold_f;

  always_comb begin
    fold_s = p_q;
    fold_x = {fold_s[31], fold_s};
    if (fold_s > 32'sh4000_0000) begin
      fold_f = 33'sh0_8000_0000 - fold_x;
    end else if (fold_s < 32'shC000_0000) begin
      fold_f = 33'sh1_8000_0000 - fold_x;
    end else begin
      fold_f = fold_x;
    end
  end

  // Signed integer to single precision, truncating
  logic        conv_neg;
  logic [31:0] conv_mag;
  logic [4:0]  conv_msb;
  logic [31:0] conv_norm;
  logic [7:0]  conv_exp;
  logic [31:0] conv_float;

  always_comb begin
    conv_neg = fold_q[31];
    conv_mag = conv_neg ? (~fold_q + 32'd1) : fold_q;
    conv_msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (conv_mag[i]) begin
        conv_msb = 5'(i);
      end
    end
    conv_norm  = conv_mag << (5'd31 - conv_msb);
    conv_exp   = 8'd127 + {3'b000, conv_msb};
    conv_float = (conv_mag == '0) ? '0 : {conv_neg, conv_exp, conv_norm[30:8]};
  end

  // Float multiplier: normal operands only, truncated mantissa, zero if either input is zero
  logic        mul_rst;
  logic        mul_done;
  logic [23:0] mul_ma;
  logic [23:0] mul_mb;
  logic [47:0] mul_prod;
  logic [9:0]  mul_exp;
  logic [22:0] mul_mant;
  logic        mul_zero;
  logic [31:0] mul_res;

  always_comb begin
    mul_ma   = {1'b1, conv_q[22:0]};
    mul_mb   = {1'b1, SCALE[22:0]};
    mul_prod = 48'(mul_ma) * 48'(mul_mb);
    mul_exp  = {2'b00, conv_q[30:23]} + {2'b00, SCALE[30:23]} - 10'd127
               + {9'd0, mul_prod[47]};
    mul_mant = mul_prod[47] ? mul_prod[46:24] : mul_prod[45:23];
    mul_zero = (conv_q[30:23] == 8'd0) || (SCALE[30:23] == 8'd0);
    mul_res  = mul_zero ? '0 : {conv_q[31] ^ SCALE[31], mul_exp[7:0], mul_mant};
  end

  // Multiplier holds done low for MulLat cycles after its reset pulse
  always_comb begin
    mul_rst   = (state_q == StScaleGo);
    mul_done  = (mul_cnt_q == 2'(MulLat));
    mul_cnt_d = mul_cnt_q;
    mul_res_d = mul_res_q;
    if (mul_rst) begin
      mul_cnt_d = '0;
    end else if (!mul_done) begin
      mul_cnt_d = mul_cnt_q + 2'd1;
      mul_res_d = mul_res;
    end
  end

  always_comb begin
    base    = phase_load ? phase_init : phase_q;
    phase_d = phase_q;
    if (tick) begin
      phase_d = base + phase_inc;
    end else if (phase_load) begin
      phase_d = phase_init;
    end
  end

  always_comb begin
    state_d        = state_q;
    p_d            = p_q;
    fold_d         = fold_q;
    conv_d         = conv_q;
    theta_d        = theta_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    first_d        = (state_q == StScaleGo);
    overrun_d      = overrun_q | (tick && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          p_d     = base;
          state_d = StFold;
        end
      end
      StFold: begin
        fold_d  = fold_f[31:0];
        state_d = StConv;
      end
      StConv: begin
        conv_d  = conv_float;
        state_d = StScaleGo;
      end
      StScaleGo: begin
        state_d = StScaleWait;
      end
      StScaleWait: begin
        // done still reflects the previous operation on the first cycle
        if (!first_q && mul_done) begin
          theta_d = mul_res_q;
          state_d = StTrigGo;
        end
      end
      StTrigGo: begin
        state_d = StTrigGuard;
      end
      StTrigGuard: begin
        state_d = StTrigWait;
      end
      StTrigWait: begin
        if (trig_done) begin
          sample_d       = trig_result;
          sample_valid_d = 1'b1;
          state_d        = StOutput;
        end
      end
      StOutput: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      phase_q        <= '0;
      p_q            <= '0;
      fold_q         <= '0;
      conv_q         <= '0;
      theta_q        <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      first_q        <= 1'b0;
      mul_cnt_q      <= 2'(MulLat);
      mul_res_q      <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      p_q            <= p_d;
      fold_q         <= fold_d;
      conv_q         <= conv_d;
      theta_q        <= theta_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      first_q        <= first_d;
      mul_cnt_q      <= mul_cnt_d;
      mul_res_q      <= mul_res_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = sample_valid_q;
  assign busy         = (state_q != StIdle);
  assign overrun      = overrun_q;
  assign trig_theta   = theta_q;
  assign trig_prec    = PREC;
  assign trig_start   = (state_q == StTrigGo);

  logic unused_bits;
  assign unused_bits = ^{fold_f[32], conv_norm[31], conv_norm[7:0], mul_prod[22:0],
                         mul_exp[9:8]};

endmodule

// File: tb/tb_sin_osc_ctrl.sv
// Scoreboard bench for sin_osc_ctrl with a behavioural sin core that holds done low
// for a fixed number of cycles after each start pulse.
module tb_sin_osc_ctrl;

  localparam int LSIN = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic [31:0] phase_inc;
  logic        phase_load;
  logic [31:0] phase_init;
  logic [31:0] sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic [31:0] trig_theta;
  logic [3:0]  trig_prec;
  logic        trig_start;
  logic [31:0] trig_result;
  logic        trig_done;

  always #5 clk = ~clk;

  sin_osc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .phase_inc   (phase_inc),
    .phase_load  (phase_load),
    .phase_init  (phase_init),
    .sample      (sample),
    .sample_valid(sample_valid),
    .busy        (busy),
    .overrun     (overrun),
    .trig_theta  (trig_theta),
    .trig_prec   (trig_prec),
    .trig_start  (trig_start),
    .trig_result (trig_result),
    .trig_done   (trig_done)
  );

  // Sin core model
  logic [31:0] sin_ret = 32'h0;
  int          sin_cnt = 0;
  logic        sin_done = 1'b1;

  always @(posedge clk) begin
    if (trig_start) begin
      sin_cnt  <= LSIN;
      sin_done <= 1'b0;
    end else if (sin_cnt != 0) begin
      sin_cnt <= sin_cnt - 1;
      if (sin_cnt == 1) sin_done <= 1'b1;
    end
  end

  assign trig_done   = sin_done;
  assign trig_result = sin_done ? sin_ret : 32'hDEAD_BEEF;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_valid  = 0;

  logic [31:0] exp_theta_q[$];
  logic [31:0] exp_sample_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (trig_start) begin
      n_start++;
      if (exp_theta_q.size() == 0) check_eq("theta_sb", 32'd0, 32'd1);
      else check_eq("theta", trig_theta, exp_theta_q.pop_front());
    end
    if (sample_valid) begin
      n_valid++;
      if (exp_sample_q.size() == 0) check_eq("sample_sb", 32'd0, 32'd1);
      else check_eq("sample", sample, exp_sample_q.pop_front());
    end
  end

  task automatic start_txn(input logic load, input logic [31:0] init, input logic [31:0] inc,
                           input logic [31:0] ret, input logic [31:0] exp_theta,
                           input bit want_sample);
    @(negedge clk);
    phase_load = load;
    phase_init = init;
    phase_inc  = inc;
    tick       = 1'b1;
    sin_ret    = ret;
    exp_theta_q.push_back(exp_theta);
    if (want_sample) exp_sample_q.push_back(ret);
    @(negedge clk);
    tick       = 1'b0;
    phase_load = 1'b0;
  endtask

  task automatic wait_valid(input int v0);
    int t = 0;
    while (n_valid == v0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (n_valid == v0) check_eq("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_txn(input string tag, input logic load, input logic [31:0] init,
                         input logic [31:0] inc, input logic [31:0] ret,
                         input logic [31:0] exp_theta);
    int s0 = n_start;
    int v0 = n_valid;
    start_txn(load, init, inc, ret, exp_theta, 1'b1);
    wait_valid(v0);
    repeat (3) @(negedge clk);
    check_eq({tag, "_starts"}, 32'(n_start - s0), 32'd1);
    check_eq({tag, "_valids"}, 32'(n_valid - v0), 32'd1);
    check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    int v0;
    int t;
    reset      = 1'b1;
    tick       = 1'b0;
    phase_inc  = 32'h100;
    phase_load = 1'b0;
    phase_init = 32'h0;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("rst_sample", sample, 32'd0);
    check_eq("rst_valid", {31'd0, sample_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_start", {31'd0, trig_start}, 32'd0);
    check_eq("rst_theta", trig_theta, 32'd0);
    check_eq("prec", {28'd0, trig_prec}, 32'd5);
    reset = 1'b0;

    // Phase must still be zero after reset despite ticks during reset
    run_txn("post_rst", 1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'h0000_0000);
    run_txn("quarter", 1'b1, 32'h4000_0000, 32'h0, 32'h3F80_0000, 32'h3FC9_0FDB);
    run_txn("fold_zero", 1'b1, 32'h8000_0000, 32'h0, 32'hABCD_EF01, 32'h0000_0000);
    run_txn("neg_quarter", 1'b1, 32'hC000_0000, 32'h0, 32'hBF80_0000, 32'hBFC9_0FDB);
    run_txn("mid_fold", 1'b1, 32'h6000_0000, 32'h0, 32'h3F35_04F3, 32'h3F49_0FDB);
    run_txn("neg_mid_fold", 1'b1, 32'hA000_0000, 32'h0, 32'hBF35_04F3, 32'hBF49_0FDB);
    run_txn("direct", 1'b1, 32'h2000_0000, 32'h0, 32'h3F00_0000, 32'h3F49_0FDB);
    check_eq("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Overrun: second tick while busy; phase wraps 0xFFFFFFF0 -> 0x10 -> 0x30
    s0 = n_start;
    v0 = n_valid;
    start_txn(1'b1, 32'hFFFF_FFF0, 32'h20, 32'h1111_1111, 32'hB2C9_0FDB, 1'b1);
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_eq("overrun_set", {31'd0, overrun}, 32'd1);
    wait_valid(v0);
    repeat (5) @(negedge clk);
    check_eq("ovr_starts", 32'(n_start - s0), 32'd1);
    check_eq("ovr_valids", 32'(n_valid - v0), 32'd1);
    check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

    // p = 0x30 = 48; 48 * 2pi/2^32 as float
    run_txn("phase_0x30", 1'b0, 32'h0, 32'h0, 32'h2222_2222, 32'h3396_CBE4);
    check_eq("overrun_still", {31'd0, overrun}, 32'd1);

    // Reset while waiting on the sin core
    s0 = n_start;
    v0 = n_valid;
    start_txn(1'b1, 32'h4000_0000, 32'h0, 32'h3333_3333, 32'h3FC9_0FDB, 1'b0);
    t = 0;
    while (n_start == s0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (n_start == s0) check_eq("start_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
    check_eq("in_trig_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_overrun", {31'd0, overrun}, 32'd0);
    check_eq("abort_sample", sample, 32'd0);
    repeat (20) @(negedge clk);
    check_eq("abort_no_valid", 32'(n_valid - v0), 32'd0);
    check_eq("abort_idle", {31'd0, busy}, 32'd0);

    run_txn("after_abort", 1'b0, 32'h0, 32'h0, 32'h4444_4444, 32'h0000_0000);

    check_eq("theta_sb_empty", 32'(exp_theta_q.size()), 32'd0);
    check_eq("sample_sb_empty", 32'(exp_sample_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
